// File: rtl/multiport_regfile.sv
// Multi-ported integer register file with optional hard-wired x0, write-to-read
// bypass and a per-register busy scoreboard for the decode/writeback stages.
module multiport_regfile #(
   parameter int ADDR_WIDTH = 5,
   parameter int WORD_LEN   = 32,
   parameter int NR_READ    = 2,
   parameter int NR_WRITE   = 2,
   parameter int ZERO_REG   = 1,
   parameter int BYPASS     = 1
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [NR_READ*ADDR_WIDTH-1:0]  raddr,
   output logic [NR_READ*WORD_LEN-1:0]    rdata,
   output logic [NR_READ-1:0]             rbusy,
   input  logic [NR_WRITE-1:0]            wen,
   input  logic [NR_WRITE*ADDR_WIDTH-1:0] waddr,
   input  logic [NR_WRITE*WORD_LEN-1:0]   wdata,
   input  logic                           busy_set,
   input  logic [ADDR_WIDTH-1:0]          busy_addr,
   output logic                           wconflict,
   input  logic [ADDR_WIDTH-1:0]          dbg_addr,
   output logic [WORD_LEN-1:0]            dbg_data
);

   localparam int  DEPTH = 2 ** ADDR_WIDTH;
   localparam bit  ZR    = (ZERO_REG != 0);
   localparam bit  BP    = (BYPASS != 0);

   logic [WORD_LEN-1:0] regs [DEPTH];
   logic [DEPTH-1:0]    busy;
   logic [NR_WRITE-1:0] wvalid;
   logic                conflict_now;

   // A write that targets a hard-wired x0 is dropped everywhere: storage, busy
   // clearing, bypass and collision detection.
   always_comb begin
      wvalid = '0;
      for (int w = 0; w < NR_WRITE; w++) begin
         wvalid[w] = wen[w] && !(ZR && waddr[w*ADDR_WIDTH +: ADDR_WIDTH] == '0);
      end
   end

   always_comb begin
      conflict_now = 1'b0;
      for (int i = 0; i < NR_WRITE; i++) begin
         for (int j = i + 1; j < NR_WRITE; j++) begin
            if (wvalid[i] && wvalid[j] &&
                waddr[i*ADDR_WIDTH +: ADDR_WIDTH] == waddr[j*ADDR_WIDTH +: ADDR_WIDTH]) begin
               conflict_now = 1'b1;
            end
         end
      end
   end

   // Ports are applied in ascending order so the highest-index writer lands last;
   // busy_set follows the clears so a newly issued producer keeps its bit.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs[i] <= '0;
         end
         busy      <= '0;
         wconflict <= 1'b0;
      end else begin
         for (int w = 0; w < NR_WRITE; w++) begin
            if (wvalid[w]) begin
               regs[waddr[w*ADDR_WIDTH +: ADDR_WIDTH]] <= wdata[w*WORD_LEN +: WORD_LEN];
               busy[waddr[w*ADDR_WIDTH +: ADDR_WIDTH]] <= 1'b0;
            end
         end
         if (busy_set && !(ZR && busy_addr == '0)) begin
            busy[busy_addr] <= 1'b1;
         end
         wconflict <= conflict_now;
      end
   end

   for (genvar r = 0; r < NR_READ; r++) begin : g_read
      logic [ADDR_WIDTH-1:0] ra;
      logic [WORD_LEN-1:0]   data;
      logic                  pending;

      assign ra = raddr[r*ADDR_WIDTH +: ADDR_WIDTH];

      always_comb begin
         data    = regs[ra];
         pending = busy[ra];
         if (BP) begin
            for (int w = 0; w < NR_WRITE; w++) begin
               if (wvalid[w] && waddr[w*ADDR_WIDTH +: ADDR_WIDTH] == ra) begin
                  data    = wdata[w*WORD_LEN +: WORD_LEN];
                  pending = 1'b0;
               end
            end
         end
         if (ZR && ra == '0) begin
            data    = '0;
            pending = 1'b0;
         end
      end

      assign rdata[r*WORD_LEN +: WORD_LEN] = data;
      assign rbusy[r]                      = pending;
   end

   assign dbg_data = (ZR && dbg_addr == '0) ? '0 : regs[dbg_addr];

endmodule
